// File: rtl/prim_generic_skid_slice.sv
// Two-entry elastic register slice: a head (main) register plus a skid register,
// so both the forward valid/data path and the backward ready path are registered.
module prim_generic_skid_slice #(
  parameter int unsigned           Width      = 32,
  parameter logic [Width-1:0]      ResetValue = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [Width-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [Width-1:0] out_data_o,
  output logic [1:0]       occupancy_o
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } state_e;

  state_e           state_reg, state_next;
  logic [Width-1:0] main_reg, main_next;
  logic [Width-1:0] skid_reg, skid_next;
  logic             in_ready_reg;
  logic             push, pop;

  assign push = in_valid_i & in_ready_reg;
  assign pop  = out_valid_o & out_ready_i;

  always_comb begin
    state_next = state_reg;
    main_next  = main_reg;
    skid_next  = skid_reg;
    unique case (state_reg)
      StEmpty: begin
        if (push) begin
          state_next = StOne;
          main_next  = in_data_i;
        end
      end
      StOne: begin
        if (push && pop) begin
          main_next = in_data_i;
        end else if (push) begin
          // Head is stalled: park the new word in the skid register.
          state_next = StTwo;
          skid_next  = in_data_i;
        end else if (pop) begin
          state_next = StEmpty;
        end
      end
      StTwo: begin
        // in_ready is low here, so only a pop can move the slice.
        if (pop) begin
          state_next = StOne;
          main_next  = skid_reg;
        end
      end
      default: begin
        state_next = StEmpty;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg    <= StEmpty;
      main_reg     <= ResetValue;
      skid_reg     <= ResetValue;
      in_ready_reg <= 1'b1;
    end else begin
      state_reg    <= state_next;
      main_reg     <= main_next;
      skid_reg     <= skid_next;
      in_ready_reg <= (state_next != StTwo);
    end
  end

  assign in_ready_o  = in_ready_reg;
  assign out_valid_o = (state_reg != StEmpty);
  assign out_data_o  = main_reg;

  always_comb begin
    occupancy_o = 2'd0;
    unique case (state_reg)
      StEmpty: occupancy_o = 2'd0;
      StOne:   occupancy_o = 2'd1;
      StTwo:   occupancy_o = 2'd2;
      default: occupancy_o = 2'd0;
    endcase
  end

  occupancy_bound_a : assert property (@(posedge clk_i) occupancy_o <= 2'd2);

  no_push_when_full_a : assert property (@(posedge clk_i) disable iff (rst_i)
    !((state_reg == StTwo) && push));

  stall_stable_a : assert property (@(posedge clk_i) disable iff (rst_i)
    (out_valid_o && !out_ready_i) |=> (out_valid_o && $stable(out_data_o)));

endmodule

// File: tb/tb_prim_generic_skid_slice.sv
// Bench for prim_generic_skid_slice: a queue model of the slice is checked every
// cycle, with directed scenarios pinned by literal expectations and a random run.
module tb_prim_generic_skid_slice;

  localparam int unsigned     W  = 8;
  localparam logic [W-1:0]    RV = 8'hA5;

  logic         clk_i;
  logic         rst_i;
  logic         in_valid_i;
  logic         in_ready_o;
  logic [W-1:0] in_data_i;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [W-1:0] out_data_o;
  logic [1:0]   occupancy_o;

  prim_generic_skid_slice #(.Width(W), .ResetValue(RV)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .occupancy_o (occupancy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: words held, oldest first; the head register keeps the last head word.
  logic [W-1:0] q[$];
  logic [W-1:0] last_head;
  logic [W-1:0] accepted[$];
  logic [W-1:0] emitted[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then compare.
  task automatic cycle(input logic v, input logic [W-1:0] d, input logic r, input logic rst);
    bit push, pop;
    in_valid_i  = v;
    in_data_i   = d;
    out_ready_i = r;
    rst_i       = rst;
    @(posedge clk_i);
    if (rst) begin
      q.delete();
      last_head = RV;
    end else begin
      push = v && (q.size() < 2);
      pop  = r && (q.size() > 0);
      if (pop) emitted.push_back(q.pop_front());
      if (push) begin
        q.push_back(d);
        accepted.push_back(d);
      end
      if (q.size() > 0) last_head = q[0];
    end
    #1;
    check("out_valid", {31'd0, out_valid_o}, {31'd0, q.size() > 0});
    check("in_ready", {31'd0, in_ready_o}, {31'd0, q.size() < 2});
    check("occupancy", {30'd0, occupancy_o}, q.size());
    check("out_data", {24'd0, out_data_o}, {24'd0, last_head});
    $display("cyc v=%0d d=%02h r=%0d rst=%0d -> ov=%0d od=%02h ir=%0d occ=%0d",
             v, d, r, rst, out_valid_o, out_data_o, in_ready_o, occupancy_o);
  endtask

  initial begin
    in_valid_i  = 1'b0;
    in_data_i   = '0;
    out_ready_i = 1'b0;
    rst_i       = 1'b1;
    last_head   = RV;

    // Reset release
    cycle(1'b1, 8'hFF, 1'b1, 1'b1);
    check("rst_valid", {31'd0, out_valid_o}, 32'd0);
    check("rst_ready", {31'd0, in_ready_o}, 32'd1);
    check("rst_occ", {30'd0, occupancy_o}, 32'd0);
    check("rst_data", {24'd0, out_data_o}, 32'hA5);

    // Streaming at full throughput
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1, W'(i), 1'b1, 1'b0);
      check("stream_data", {24'd0, out_data_o}, i);
      check("stream_occ", {30'd0, occupancy_o}, 32'd1);
      check("stream_ready", {31'd0, in_ready_o}, 32'd1);
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("drain_valid", {31'd0, out_valid_o}, 32'd0);

    // Backpressure fills the skid register, then drains in order
    cycle(1'b1, 8'h11, 1'b0, 1'b0);
    cycle(1'b1, 8'h22, 1'b0, 1'b0);
    check("bp_ready", {31'd0, in_ready_o}, 32'd0);
    check("bp_occ", {30'd0, occupancy_o}, 32'd2);
    cycle(1'b1, 8'h33, 1'b0, 1'b0);
    check("bp_hold_data", {24'd0, out_data_o}, 32'h11);
    check("bp_hold_occ", {30'd0, occupancy_o}, 32'd2);
    cycle(1'b1, 8'h33, 1'b1, 1'b0);
    check("bp_pop1", {24'd0, out_data_o}, 32'h22);
    check("bp_ready_back", {31'd0, in_ready_o}, 32'd1);
    cycle(1'b1, 8'h33, 1'b1, 1'b0);
    check("bp_pop2", {24'd0, out_data_o}, 32'h33);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("bp_empty", {31'd0, out_valid_o}, 32'd0);
    check("bp_retained", {24'd0, out_data_o}, 32'h33);

    // Simultaneous push and pop in ONE
    cycle(1'b1, 8'h40, 1'b0, 1'b0);
    cycle(1'b1, 8'h41, 1'b1, 1'b0);
    check("pp_data", {24'd0, out_data_o}, 32'h41);
    check("pp_occ", {30'd0, occupancy_o}, 32'd1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Reset while holding two words
    cycle(1'b1, 8'h55, 1'b0, 1'b0);
    cycle(1'b1, 8'h66, 1'b0, 1'b0);
    check("two_occ", {30'd0, occupancy_o}, 32'd2);
    cycle(1'b1, 8'h77, 1'b1, 1'b1);
    check("mrst_valid", {31'd0, out_valid_o}, 32'd0);
    check("mrst_data", {24'd0, out_data_o}, 32'hA5);
    check("mrst_ready", {31'd0, in_ready_o}, 32'd1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("mrst_still_empty", {30'd0, occupancy_o}, 32'd0);

    // Random traffic
    accepted.delete();
    emitted.delete();
    for (int i = 0; i < 10000; i++) begin
      cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 2) != 0), 1'b0);
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("rand_count", emitted.size(), accepted.size());
    begin
      int bad = 0;
      for (int i = 0; i < emitted.size() && i < accepted.size(); i++)
        if (emitted[i] !== accepted[i]) bad++;
      check("rand_order", bad, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Stall stability observed directly on the DUT pins.
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_data  = '0;
  always @(posedge clk_i) begin
    #2;
    if (prev_stall && !rst_i) begin
      check("stall_valid", {31'd0, out_valid_o}, 32'd1);
      check("stall_data", {24'd0, out_data_o}, {24'd0, prev_data});
    end
    prev_stall = out_valid_o && !out_ready_i && !rst_i;
    prev_data  = out_data_o;
  end

endmodule

// File: doc/prim_generic_skid_slice.md
Name: prim_generic_skid_slice

Overview:
- Two-entry elastic register slice with valid/ready handshakes on both sides. It is the consumer-facing counterpart of a plain flop stage.
- Upstream pushes words in; downstream drains them under backpressure. No word is lost or duplicated.
- in_ready_o is driven only from flops, so the slice breaks both the forward (valid/data) and backward (ready) combinational paths.
- Used between ibex pipeline stages and bus adapters where downstream stalls must not reach upstream in the same cycle.

Parameters:
- Width, 32, data word width in bits (>=1).
- ResetValue, '0, value of the main and skid data registers, and therefore of out_data_o, after reset.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset, synchronous, active-high.
- in_valid_i  input  1  upstream offers in_data_i.
- in_ready_o  output  1  slice can accept a word; driven directly from a flop.
- in_data_i  input  Width  upstream data word.
- out_valid_o  output  1  out_data_o holds a valid word.
- out_ready_i  input  1  downstream consumes the word this cycle.
- out_data_o  output  Width  head word; driven directly from the main register.
- occupancy_o  output  2  number of words held: 0, 1 or 2.

Behaviour:
- Handshake definitions:
  - push = in_valid_i & in_ready_o
  - pop = out_valid_o & out_ready_i
  - Transfers are evaluated at the rising edge.
- Storage: main register (head) and skid register, plus state EMPTY/ONE/TWO.
- Derived outputs:
  - out_valid_o = (state != EMPTY)
  - in_ready_o = registered (next_state != TWO)
  - occupancy_o = 0/1/2 for EMPTY/ONE/TWO
- Reset (rst_i high at an edge):
  - State goes to EMPTY; out_valid_o=0, occupancy_o=0, in_ready_o=1.
  - Main and skid registers go to ResetValue.
  - Any push or pop presented in the same cycle is discarded.
  - Reset mid-operation drops all held words.
- EMPTY:
  - push -> ONE, main<=in_data_i.
  - Otherwise hold.
  - out_ready_i is ignored.
- ONE:
  - push & pop -> ONE, main<=in_data_i (full throughput, one word per cycle).
  - push & !pop -> TWO, skid<=in_data_i; main holds; in_ready_o goes 0 next cycle.
  - !push & pop -> EMPTY.
  - Neither -> hold.
- TWO:
  - in_ready_o=0, so push cannot occur; in_valid_i and in_data_i are ignored.
  - pop -> ONE, main<=skid; in_ready_o goes 1 next cycle.
  - Otherwise hold.
- Latency: a word pushed at edge N is visible on out_data_o with out_valid_o=1 after edge N (one cycle). No combinational path from in_* to out_*.
- Ordering: strictly FIFO. The skid word never overtakes the main word.
- Stability: while out_valid_o=1 and out_ready_i=0, out_data_o and out_valid_o hold their values.
- Upstream rules: in_valid_i may be withdrawn while in_ready_o=0 without effect. in_data_i is sampled only on push.
- Unused register contents keep their last values (no clearing on pop); only reset clears them.
- Assertions required in RTL:
  - occupancy_o never exceeds 2.
  - No push while state==TWO.
  - out_data_o stable under stall.

Test Plan:
- Reset release with Width=8, ResetValue=8'hA5 -> out_valid_o=0, in_ready_o=1, occupancy_o=0, out_data_o=8'hA5.
- Streaming: push 8'h01..8'h08 on consecutive cycles with out_ready_i=1 -> out_data_o shows 01..08 one cycle later, one per cycle; in_ready_o stays 1; occupancy_o stays 1.
- Backpressure: out_ready_i=0, push 8'h11, 8'h22, 8'h33 -> 11 and 22 accepted; in_ready_o=0 the cycle after 22; occupancy_o=2; 33 held upstream. Raise out_ready_i -> outputs 11, 22, 33 in order; no loss or duplicate.
- Simultaneous push and pop in ONE (main=8'h40, push 8'h41 with out_ready_i=1) -> occupancy stays 1; out_data_o=8'h41 next cycle.
- Reset mid-operation in TWO (held 8'h55, 8'h66), rst_i high one cycle with in_valid_i=1 and out_ready_i=1 -> next cycle EMPTY, out_data_o=ResetValue, no word emitted or accepted.
- Random in_valid_i/out_ready_i for 10k cycles against a scoreboard -> output sequence equals accepted input sequence. out_data_o never changes while out_valid_o=1 and out_ready_i=0.
